// File: rtl/inst_rom_loader.sv
// Instruction memory with a byte-serial boot loader. Holds the core in reset while the image
// streams in, then serves fetches through a combinational read port.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           inst_o,
  output logic                  cpu_rst_o,
  output logic [ADDR_WIDTH:0]   words_o,
  output logic                  overflow_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  ovf_q, ovf_d;

  logic [31:0]           mem_q [Depth];

  logic                  accept;
  logic                  word_we;
  logic [31:0]           word_merged;
  logic [ADDR_WIDTH-1:0] read_idx;
  logic                  unused_addr;

  assign accept  = ld_valid_i && (state_q == StLoad);
  assign word_we = accept && (ld_last_i || (idx_q == 2'd3));

  // Current byte lands big-endian on top of the held bytes; unfilled lanes stay zero.
  always_comb begin
    word_merged = asm_q;
    case (idx_q)
      2'd0:    word_merged[31:24] = ld_data_i;
      2'd1:    word_merged[23:16] = ld_data_i;
      2'd2:    word_merged[15:8]  = ld_data_i;
      default: word_merged[7:0]   = ld_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    if (accept) begin
      if (word_we) begin
        asm_d   = '0;
        idx_d   = 2'd0;
        wptr_d  = wptr_q + 1'b1;
        words_d = words_q + 1'b1;
        if (ld_last_i) begin
          state_d = StRun;
        end else if (wptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StRun;
          ovf_d   = 1'b1;
        end
      end else begin
        asm_d = word_merged;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      wptr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  // Array is deliberately not reset so a warm reset keeps the previous image.
  always_ff @(posedge clk) begin
    if (!rst && word_we) begin
      mem_q[wptr_q] <= word_merged;
    end
  end

  assign read_idx    = addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  assign inst_o     = (ce_i && (state_q == StRun)) ? mem_q[read_idx] : 32'h0;
  assign ld_ready_o = (state_q == StLoad);
  assign cpu_rst_o  = (state_q != StRun);
  assign words_o    = words_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a full-depth and a 4-word instance share the stimulus and
// are checked every cycle against a byte-queue model, plus literal spot checks.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h0;
  logic        ld_last = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;

  logic        ready_a, ready_b, crst_a, crst_b, ovf_a, ovf_b;
  logic [31:0] inst_a, inst_b;
  logic [10:0] words_a;
  logic [2:0]  words_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_rom_loader u_big (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready_a), .ce_i(ce), .addr_i(addr), .inst_o(inst_a), .cpu_rst_o(crst_a),
    .words_o(words_a), .overflow_o(ovf_a)
  );

  inst_rom_loader #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(ready_b), .ce_i(ce), .addr_i(addr), .inst_o(inst_b), .cpu_rst_o(crst_b),
    .words_o(words_b), .overflow_o(ovf_b)
  );

  // Model: per instance, a list of pending bytes and a word array.
  int          dep [2] = '{1024, 4};
  bit          m_run [2];
  bit          m_ovf [2];
  int          m_words [2];
  int          m_wptr [2];
  int          m_nb [2];
  logic [7:0]  m_pend [2][4];
  logic [31:0] m_mem [2][1024];
  bit          m_wr [2][1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_ovf[i] = 0; m_words[i] = 0; m_wptr[i] = 0; m_nb[i] = 0;
      end else if (!m_run[i] && ld_valid) begin
        m_pend[i][m_nb[i]] = ld_data;
        m_nb[i]++;
        if (ld_last || m_nb[i] == 4) begin
          logic [31:0] w;
          w = 32'h0;
          for (int j = 0; j < m_nb[i]; j++) w = w | (32'(m_pend[i][j]) << (24 - 8 * j));
          m_mem[i][m_wptr[i]] = w;
          m_wr[i][m_wptr[i]] = 1'b1;
          m_words[i]++;
          m_nb[i] = 0;
          if (ld_last) m_run[i] = 1;
          else if (m_wptr[i] == dep[i] - 1) begin
            m_run[i] = 1;
            m_ovf[i] = 1;
          end
          m_wptr[i]++;
        end
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] act_inst, act_words, exp_inst;
      logic        act_rdy, act_crst, act_ovf;
      int          ridx;
      bit          known;
      act_inst  = (i == 0) ? inst_a : inst_b;
      act_words = (i == 0) ? 32'(words_a) : 32'(words_b);
      act_rdy   = (i == 0) ? ready_a : ready_b;
      act_crst  = (i == 0) ? crst_a : crst_b;
      act_ovf   = (i == 0) ? ovf_a : ovf_b;
      ridx      = int'((addr >> 2) % dep[i]);
      known     = 1'b1;
      exp_inst  = 32'h0;
      if (ce && m_run[i]) begin
        known    = m_wr[i][ridx];
        exp_inst = m_mem[i][ridx];
      end
      check($sformatf("cpu_rst[%0d]", i), 32'(act_crst), 32'(!m_run[i]));
      check($sformatf("ld_ready[%0d]", i), 32'(act_rdy), 32'(!m_run[i]));
      check($sformatf("words[%0d]", i), act_words, m_words[i]);
      check($sformatf("overflow[%0d]", i), 32'(act_ovf), 32'(m_ovf[i]));
      if (known) check($sformatf("inst[%0d]", i), act_inst, exp_inst);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ce = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic read_at(input logic [31:0] a, input logic c);
    ce = c; addr = a;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] img6 [6];
    img6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state and single-word image
    do_reset();
    @(negedge clk);
    check("reset cpu_rst", 32'(crst_a), 32'h1);
    check("reset words", 32'(words_a), 32'h0);
    send(8'h34, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0);
    ld_valid = 1'b1; ld_data = 8'h20; ld_last = 1'b1; ce = 1'b1; addr = 32'h0;
    @(negedge clk);
    check("cpu_rst before last edge", 32'(crst_a), 32'h1);
    check("inst during load", inst_a, 32'h0);
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("cpu_rst after last edge", 32'(crst_a), 32'h0);
    check("t1 inst", inst_a, 32'h34020020);
    check("t1 words", 32'(words_a), 32'h1);
    check("t1 overflow", 32'(ovf_a), 32'h0);

    // Partial final word
    do_reset();
    for (int i = 0; i < 6; i++) send(img6[i], i == 5);
    read_at(32'h4, 1'b1);
    check("t2 inst addr4", inst_a, 32'h55660000);
    check("t2 words", 32'(words_a), 32'h2);
    read_at(32'h5, 1'b1);
    check("t2 inst addr5", inst_a, 32'h55660000);
    read_at(32'h0, 1'b1);
    check("t2 inst addr0", inst_a, 32'h11223344);

    // Bubbles between bytes
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(); cyc();
      send(8'(i + 1), i == 7);
    end
    read_at(32'h0, 1'b1);
    check("t3 word0", inst_a, 32'h01020304);
    read_at(32'h4, 1'b1);
    check("t3 word1", inst_a, 32'h05060708);
    read_at(32'h4, 1'b0);
    check("t3 ce low", inst_a, 32'h0);

    // Overflow on the 4-word instance, no last marker
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 16) begin
        ld_valid = 1'b1; ld_data = 8'hA0 + 8'(i);
        @(negedge clk);
        check("t4 small ready byte17", 32'(ready_b), 32'h0);
        check("t4 small overflow", 32'(ovf_b), 32'h1);
        check("t4 small words", 32'(words_b), 32'h4);
        check("t4 small cpu_rst", 32'(crst_b), 32'h0);
      end
      send(8'hA0 + 8'(i), 1'b0);
    end
    read_at(32'h10, 1'b1);
    check("t4 small wrap", inst_b, 32'hA0A1A2A3);
    check("t4 big still loading", inst_a, 32'h0);
    check("t4 big words", 32'(words_a), 32'h5);
    read_at(32'hC, 1'b1);
    check("t4 small word3", inst_b, 32'hACADAEAF);

    // Reset mid-load restarts byte assembly
    do_reset();
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5 cpu_rst in reset", 32'(crst_a), 32'h1);
    cyc();
    rst = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    read_at(32'h0, 1'b1);
    check("t5 inst", inst_a, 32'hAABBCCDD);
    check("t5 words", 32'(words_a), 32'h1);
    check("t5 small inst", inst_b, 32'hAABBCCDD);

    ce = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
